// File: rtl/lut_1596_pkg.sv
// Shared types and constants for the lut_1596 family: FSM state encoding,
// code/count widths and the reference truth table of lut_1596.
package lut_1596_pkg;

    localparam int CODE_W = 4;
    localparam int CNT_W  = 5;

    // Bit k holds f(k); set for codes 4, 8 and 10.
    localparam logic [15:0] LUT_1596_TRUTH = 16'h0510;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/lut_1596.sv
// Combinational lut_1596: 4-bit code in, 1-bit function value out.
module lut_1596 (
    input  logic [3:0] x_i,
    output logic       y_o
);

    always_comb begin
        y_o = 1'b0;
        case (x_i)
            4'd4, 4'd8, 4'd10: y_o = 1'b1;
            default:           y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lut_1596_minterm_enum.sv
// Sweeps all 16 codes through lut_1596 and streams out, over valid/ready,
// every code whose output equals the requested target; reports the match count.
module lut_1596_minterm_enum
    import lut_1596_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              target_i,
    output logic [CODE_W-1:0] x_o,
    output logic              x_valid_o,
    input  logic              x_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CODE_W-1:0] IDX_LAST = {CODE_W{1'b1}};

    state_e            state_q, state_d;
    logic [CODE_W-1:0] idx_q, idx_d;
    logic [CODE_W-1:0] x_q, x_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tgt_q, tgt_d;
    logic              y;

    lut_1596 u_lut (
        .x_i (idx_q),
        .y_o (y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tgt_d   = target_i;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (y == tgt_q) begin
                    x_d     = idx_q;
                    state_d = EMIT;
                end else if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            EMIT: begin
                // The last code ends the sweep here so idx never wraps to a second pass.
                if (x_ready_i) begin
                    cnt_d = cnt_q + 5'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    assign x_o       = x_q;
    assign x_valid_o = (state_q == EMIT);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign count_o   = cnt_q;

endmodule

// File: tb/tb_lut_1596_minterm_enum.sv
// Scoreboard bench for lut_1596_minterm_enum: stimulus queues expected codes and
// done events with their cycle; a negedge monitor pops and compares them.
module tb_lut_1596_minterm_enum;
    import lut_1596_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              target_i = 1'b0;
    logic [CODE_W-1:0] x_o;
    logic              x_valid_o;
    logic              x_ready_i = 1'b1;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  count_o;

    typedef struct {
        int x;
        int cyc;
    } xexp_t;

    typedef struct {
        int cnt;
        int cyc;
    } dexp_t;

    xexp_t x_q[$];
    dexp_t d_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    lut_1596_minterm_enum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .target_i  (target_i),
        .x_o       (x_o),
        .x_valid_o (x_valid_o),
        .x_ready_i (x_ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshakes, stalls and done pulses are checked against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (x_valid_o && x_ready_i) begin
                if (x_q.size() == 0) begin
                    chk("unexpected_x_valid", 1, 0);
                end else begin
                    xexp_t e;
                    e = x_q.pop_front();
                    chk("x_code", int'(x_o), e.x);
                    chk("x_cycle", cyc, e.cyc);
                end
            end else if (x_valid_o && x_q.size() != 0) begin
                chk("x_stable_stall", int'(x_o), x_q[0].x);
            end
            if (done_o) begin
                if (d_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dexp_t d;
                    d = d_q.pop_front();
                    chk("done_count", int'(count_o), d.cnt);
                    chk("done_cycle", cyc, d.cyc);
                end
            end
        end
    end

    // Drive start for one sampling edge; returns the cyc value after that edge.
    task automatic issue_start(input logic tgt, input logic hold, output int e);
        start_i  = 1'b1;
        target_i = tgt;
        @(posedge clk);
        #1;
        e = cyc;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((x_q.size() != 0 || d_q.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (x_q.size() != 0 || d_q.size() != 0) begin
            chk("drain_timeout", 1, 0);
            x_q.delete();
            d_q.delete();
        end
    endtask

    task automatic push_std3(input int e);
        x_q.push_back('{4, e + 5});
        x_q.push_back('{8, e + 10});
        x_q.push_back('{10, e + 13});
        d_q.push_back('{3, e + 19});
    endtask

    initial begin
        int e;
        int m;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_o", int'(x_o), 0);
        chk("rst_x_valid", int'(x_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_count", int'(count_o), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Target 1, ready high; next start issued in the first IDLE cycle.
        x_ready_i = 1'b1;
        issue_start(1'b1, 1'b0, e);
        push_std3(e);
        chk("busy_rise", int'(busy_o), 1);
        wait_until(e + 20);
        chk("idle_after_done", int'(busy_o), 0);
        chk("count_hold", int'(count_o), 3);

        // Target 0 at the earliest accepted start.
        issue_start(1'b0, 1'b0, e);
        chk("early_start_busy", int'(busy_o), 1);
        chk("count_cleared", int'(count_o), 0);
        m = 0;
        for (int k = 0; k < 16; k++) begin
            if (LUT_1596_TRUTH[k] == 1'b0) begin
                x_q.push_back('{k, e + 1 + k + m});
                m++;
            end
        end
        d_q.push_back('{13, e + 29});
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("count_t0_hold", int'(count_o), 13);

        // Five-cycle stall while x=8 is presented.
        issue_start(1'b1, 1'b0, e);
        x_q.push_back('{4, e + 5});
        x_q.push_back('{8, e + 15});
        x_q.push_back('{10, e + 18});
        d_q.push_back('{3, e + 24});
        wait_until(e + 10);
        chk("stall_valid", int'(x_valid_o), 1);
        x_ready_i = 1'b0;
        wait_until(e + 15);
        chk("stall_x_o", int'(x_o), 8);
        x_ready_i = 1'b1;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        // start held through the sweep and the DONE cycle, target toggled mid-sweep.
        issue_start(1'b1, 1'b1, e);
        push_std3(e);
        wait_until(e + 8);
        target_i = 1'b0;
        wait_until(e + 20);
        start_i = 1'b0;
        chk("held_start_idle", int'(busy_o), 0);
        @(posedge clk);
        #1;
        chk("done_cycle_start_ignored", int'(busy_o), 0);
        chk("held_count", int'(count_o), 3);
        wait_drain();

        // Reset while EMIT holds x=8.
        issue_start(1'b1, 1'b0, e);
        x_q.push_back('{4, e + 5});
        x_q.push_back('{8, e + 1000});
        wait_until(e + 10);
        x_ready_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        x_ready_i = 1'b1;
        chk("abort_x_o", int'(x_o), 0);
        chk("abort_valid", int'(x_valid_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_done", int'(done_o), 0);
        chk("abort_count", int'(count_o), 0);
        chk("abort_pending", x_q.size(), 1);
        x_q.delete();
        repeat (25) @(posedge clk);
        #1;
        issue_start(1'b1, 1'b0, e);
        push_std3(e);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("fresh_count", int'(count_o), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
